// File: rtl/ahb_cmd_master.sv
// AHB-Lite burst master: turns one command (read/write, start address, length)
// into a SINGLE/INCR burst of word transfers, with a one-entry write buffer.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ADDR  | first address phase (NONSEQ), no data phase outstanding
// BURST | address of beat n+1 (SEQ/BUSY) overlapping data phase of beat n
// LAST  | final data phase only
// ERR   | second cycle of an ERROR response
module ahb_cmd_master #(
   parameter int AWIDTH = 10
) (
   input  logic              HCLK,
   input  logic              HRESETN,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [4:0]        cmd_len,
   input  logic [31:0]       wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [31:0]       rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              err,
   output logic [AWIDTH-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic              HMASTLOCK,
   output logic [3:0]        HPROT,
   output logic [31:0]       HWDATA,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_BURST = 3'd2,
      S_LAST  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   state_t      state, state_nxt;
   logic [4:0]  len_c;
   logic [4:0]  addr_cnt;
   logic [4:0]  fetch_cnt;
   logic        buf_full;
   logic [31:0] buf_data;
   logic        dp_pend;
   logic        busy_hold;
   logic        addr_acc;
   logic        dp_done;
   logic        err_hit;
   logic        fetch;
   logic        in_data;

   assign HSIZE     = 3'b010;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = 4'b0011;

   always_comb begin
      if (cmd_len == 5'd0)       len_c = 5'd1;
      else if (cmd_len > 5'd16)  len_c = 5'd16;
      else                       len_c = cmd_len;
   end

   assign in_data   = (state == S_BURST) || (state == S_LAST);
   assign err_hit   = in_data && dp_pend && HRESP && !HREADY;
   assign dp_done   = in_data && dp_pend && HREADY && !HRESP;
   assign addr_acc  = HTRANS[1] && HREADY;
   assign cmd_ready = (state == S_IDLE);
   assign wr_ready  = ((state == S_ADDR) || (state == S_BURST)) && HWRITE && !err_hit &&
                      (fetch_cnt != 5'd0) && (!buf_full || addr_acc);
   assign fetch     = wr_ready && wr_valid;

   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cmd_valid) state_nxt = S_ADDR;
         S_ADDR:  if (addr_acc) state_nxt = (addr_cnt == 5'd1) ? S_LAST : S_BURST;
         S_BURST: begin
            if (err_hit)                               state_nxt = S_ERR;
            else if (addr_acc && (addr_cnt == 5'd1))   state_nxt = S_LAST;
         end
         S_LAST: begin
            if (err_hit)       state_nxt = S_ERR;
            else if (dp_done)  state_nxt = S_IDLE;
         end
         S_ERR:   if (HREADY) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // BUSY that was waited on stays BUSY until HREADY, even if the buffer fills meanwhile.
   always_comb begin
      HTRANS = TR_IDLE;
      case (state)
         S_ADDR:  if (!HWRITE || buf_full) HTRANS = TR_NONSEQ;
         S_BURST: if (!err_hit) HTRANS = ((!HWRITE || buf_full) && !busy_hold) ? TR_SEQ : TR_BUSY;
         default: HTRANS = TR_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         HADDR     <= '0;
         HWRITE    <= 1'b0;
         HBURST    <= 3'b000;
         HWDATA    <= '0;
         addr_cnt  <= '0;
         fetch_cnt <= '0;
         buf_full  <= 1'b0;
         buf_data  <= '0;
         dp_pend   <= 1'b0;
         busy_hold <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         rd_valid  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         busy_hold <= (HTRANS == TR_BUSY) && !HREADY;
         if (HREADY) dp_pend <= addr_acc;
         if (addr_acc) begin
            HADDR    <= HADDR + AWIDTH'(4);
            addr_cnt <= addr_cnt - 5'd1;
            if (HWRITE) HWDATA <= buf_data;
         end
         if (fetch) begin
            buf_data  <= wr_data;
            buf_full  <= 1'b1;
            fetch_cnt <= fetch_cnt - 5'd1;
         end else if (addr_acc && HWRITE) begin
            buf_full <= 1'b0;
         end
         if (dp_done && !HWRITE) begin
            rd_data  <= HRDATA;
            rd_valid <= 1'b1;
         end
         if ((state == S_LAST) && dp_done) done <= 1'b1;
         if ((state == S_ERR) && HREADY) begin
            done <= 1'b1;
            err  <= 1'b1;
         end
         if (err_hit) begin
            buf_full  <= 1'b0;
            fetch_cnt <= '0;
         end
         if ((state == S_IDLE) && cmd_valid) begin
            HADDR     <= cmd_addr & ~AWIDTH'(3);
            HWRITE    <= cmd_write;
            HBURST    <= (len_c == 5'd1) ? 3'b000 : 3'b001;
            addr_cnt  <= len_c;
            fetch_cnt <= cmd_write ? len_c : 5'd0;
            buf_full  <= 1'b0;
            dp_pend   <= 1'b0;
            busy_hold <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: AHB-Lite slave model with wait/error injection and
// queue-based scoreboards for addresses, write data, read data and completions.
module tb_ahb_cmd_master;

   logic        HCLK;
   logic        HRESETN;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [9:0]  cmd_addr;
   logic [4:0]  cmd_len;
   logic [31:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid, done, err;
   logic [9:0]  HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE, HMASTLOCK;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA, HRDATA;
   logic        HREADY, HRESP;

   ahb_cmd_master #(.AWIDTH(10)) dut (
      .HCLK(HCLK), .HRESETN(HRESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rdata(input logic [9:0] a);
      return (a == 10'h040) ? 32'hCAFE0001 : {16'hBEE0, 6'd0, a};
   endfunction

   logic [11:0] exp_addr[$];
   logic [31:0] exp_rd[$];
   logic [31:0] exp_wdata[$];
   logic        exp_done[$];

   int cyc = 0;
   int acc_cyc = 0, ns_cyc = -1, busy_cnt = 0, done_cnt = 0, rd_cnt = 0;
   logic [2:0] ns_burst = 3'b111;

   // slave model state
   int          cfg_waits = 0, cfg_err_beat = 0;
   int          beat_no, wcnt;
   logic        dp_act, dp_wr;
   logic [9:0]  dp_a;
   logic [1:0]  sn_htrans;
   logic [9:0]  sn_haddr;
   logic        sn_hwrite;

   // hold tracking
   logic        hold_valid = 1'b0, prev_hready, prev_hresp;
   logic [9:0]  prev_haddr;
   logic [2:0]  prev_ctl;
   logic [31:0] prev_hwdata;
   logic [11:0] ea;
   logic [31:0] ed;
   logic        ee;

   always @(posedge HCLK) cyc++;

   always @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         HREADY <= 1'b1; HRESP <= 1'b0; HRDATA <= '0;
         dp_act <= 1'b0; dp_wr <= 1'b0; dp_a <= '0; beat_no = 0; wcnt <= 0;
      end else if (HREADY) begin
         HRESP <= 1'b0;
         if (sn_htrans[1]) begin
            beat_no = (sn_htrans == 2'b10) ? 1 : beat_no + 1;
            dp_act <= 1'b1; dp_wr <= sn_hwrite; dp_a <= sn_haddr;
            if (beat_no == cfg_err_beat) begin
               HREADY <= 1'b0; HRESP <= 1'b1;
            end else if (cfg_waits > 0) begin
               HREADY <= 1'b0; wcnt <= cfg_waits;
            end else begin
               HREADY <= 1'b1; HRDATA <= rdata(sn_haddr);
            end
         end else begin
            dp_act <= 1'b0; HREADY <= 1'b1;
         end
      end else begin
         if (HRESP) HREADY <= 1'b1;
         else if (wcnt == 1) begin HREADY <= 1'b1; HRDATA <= rdata(dp_a); wcnt <= 0; end
         else wcnt <= wcnt - 1;
      end
   end

   always @(negedge HCLK) begin
      sn_htrans = HTRANS; sn_haddr = HADDR; sn_hwrite = HWRITE;
      if (!HRESETN) hold_valid = 1'b0;
      else begin
         if (cmd_valid && cmd_ready) begin acc_cyc = cyc; ns_cyc = -1; end
         if (HTRANS == 2'b10 && ns_cyc < 0) begin ns_cyc = cyc; ns_burst = HBURST; end
         if (HTRANS == 2'b01) busy_cnt++;
         if (HREADY && HTRANS[1]) begin
            if (exp_addr.size() == 0) chk("addr_extra", 1, 0);
            else begin
               ea = exp_addr.pop_front();
               chk("haddr", 32'(HADDR), 32'(ea[9:0]));
               chk("htrans", 32'(HTRANS), 32'(ea[11:10]));
            end
         end
         if (HREADY && !HRESP && dp_act && dp_wr) begin
            if (exp_wdata.size() == 0) chk("wdata_extra", 1, 0);
            else begin ed = exp_wdata.pop_front(); chk("hwdata", HWDATA, ed); end
         end
         if (HRESP && !HREADY) chk("err_idle", 32'(HTRANS), 0);
         if (hold_valid && !prev_hready && !prev_hresp) begin
            chk("hold_addr", 32'(HADDR), 32'(prev_haddr));
            chk("hold_ctl", 32'({HTRANS, HWRITE}), 32'(prev_ctl));
            chk("hold_wdata", HWDATA, prev_hwdata);
         end
         hold_valid = 1'b1; prev_hready = HREADY; prev_hresp = HRESP;
         prev_haddr = HADDR; prev_ctl = {HTRANS, HWRITE}; prev_hwdata = HWDATA;
         if (rd_valid) begin
            rd_cnt++;
            if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
            else begin ed = exp_rd.pop_front(); chk("rd_data", rd_data, ed); end
         end
         if (done) begin
            done_cnt++;
            chk("done_ready", 32'(cmd_ready), 1);
            if (exp_done.size() == 0) chk("done_extra", 1, 0);
            else begin ee = exp_done.pop_front(); chk("err", 32'(err), 32'(ee)); end
         end
      end
   end

   task automatic check_reset_vals();
      chk("rst_htrans", 32'(HTRANS), 0);
      chk("rst_haddr", 32'(HADDR), 0);
      chk("rst_hwrite", 32'(HWRITE), 0);
      chk("rst_hwdata", HWDATA, 0);
      chk("rst_hburst", 32'(HBURST), 0);
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_const", 32'({HSIZE, HMASTLOCK, HPROT}), 32'({3'b010, 1'b0, 4'b0011}));
   endtask

   task automatic drive_wr(input int n, input int gap_beat, input logic [31:0] seed);
      int guard;
      for (int i = 0; i < n; i++) begin
         if (gap_beat > 0 && i == gap_beat - 1) begin
            wr_valid = 1'b0;
            repeat (2) begin @(posedge HCLK); #1; end
         end
         wr_data = seed + 32'(i); wr_valid = 1'b1;
         exp_wdata.push_back(seed + 32'(i));
         guard = 0;
         do begin @(negedge HCLK); guard++; end while (!wr_ready && guard < 200);
         if (guard >= 200) begin chk("wr_timeout", 0, 1); wr_valid = 1'b0; return; end
         @(posedge HCLK); #1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int guard = 0;
      while (done_cnt == d0 && guard < 400) begin @(negedge HCLK); guard++; end
      if (done_cnt == d0) chk("done_timeout", 0, 1);
   endtask

   task automatic push_exp(input logic wr, input logic [9:0] a, input int n, input int err_beat);
      int nacc = (err_beat != 0) ? err_beat : n;
      int nrd  = (err_beat != 0) ? err_beat - 1 : n;
      logic [9:0] ba = a & 10'h3FC;
      for (int i = 0; i < nacc; i++)
         exp_addr.push_back({(i == 0) ? 2'b10 : 2'b11, 10'(ba + 10'(4 * i))});
      if (!wr) for (int i = 0; i < nrd; i++) exp_rd.push_back(rdata(10'(ba + 10'(4 * i))));
   endtask

   task automatic issue(input logic wr, input logic [9:0] a, input logic [4:0] len);
      @(posedge HCLK); #1;
      chk("cmd_ready", 32'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input logic wr, input logic [9:0] a, input logic [4:0] len,
                          input int waits, input int err_beat, input int gap_beat,
                          input int exp_lat, input logic [2:0] exp_burst, input int exp_busy);
      int n = (len == 0) ? 1 : ((len > 16) ? 16 : int'(len));
      int d0 = done_cnt;
      cfg_waits = waits; cfg_err_beat = err_beat; busy_cnt = 0;
      push_exp(wr, a, n, err_beat);
      exp_done.push_back(err_beat != 0);
      issue(wr, a, len);
      fork
         begin if (wr) drive_wr(n, gap_beat, 32'hD000_0000 + 32'(a) * 256); end
         begin wait_done(d0); end
      join
      chk("nonseq_lat", 32'(ns_cyc - acc_cyc), 32'(exp_lat));
      chk("hburst", 32'(ns_burst), 32'(exp_burst));
      chk("busy_cnt", 32'(busy_cnt), 32'(exp_busy));
      chk("left_addr", 32'(exp_addr.size()), 0);
      chk("left_rd", 32'(exp_rd.size()), 0);
      chk("left_wdata", 32'(exp_wdata.size()), 0);
      chk("left_done", 32'(exp_done.size()), 0);
   endtask

   initial begin
      int d0, r0, guard;
      HRESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_valid = 1'b0;
      repeat (3) @(posedge HCLK); #1;
      check_reset_vals();
      HRESETN = 1'b1;

      run_cmd(1'b0, 10'h040, 5'd1,  0, 0, 0, 1, 3'b000, 0);
      run_cmd(1'b1, 10'h3F8, 5'd4,  0, 0, 0, 2, 3'b001, 0);
      run_cmd(1'b1, 10'h100, 5'd4,  0, 0, 3, 2, 3'b001, 2);
      run_cmd(1'b0, 10'h200, 5'd8,  2, 0, 0, 1, 3'b001, 0);
      run_cmd(1'b0, 10'h080, 5'd4,  0, 2, 0, 1, 3'b001, 0);
      run_cmd(1'b0, 10'h043, 5'd0,  0, 0, 0, 1, 3'b000, 0);
      run_cmd(1'b0, 10'h3F0, 5'd20, 0, 0, 0, 1, 3'b001, 0);

      // reset in the middle of a waited 8-beat read
      cfg_waits = 2; cfg_err_beat = 0;
      push_exp(1'b0, 10'h300, 8, 0);
      d0 = done_cnt; r0 = rd_cnt;
      issue(1'b0, 10'h300, 5'd8);
      guard = 0;
      while (rd_cnt < r0 + 2 && guard < 200) begin @(negedge HCLK); guard++; end
      chk("rst_pre_beats", 32'(rd_cnt - r0), 2);
      @(posedge HCLK); #3;
      HRESETN = 1'b0;
      #1;
      check_reset_vals();
      exp_addr.delete(); exp_rd.delete(); exp_wdata.delete(); exp_done.delete();
      repeat (3) @(posedge HCLK); #1;
      chk("rst_no_done", 32'(done_cnt), 32'(d0));
      HRESETN = 1'b1;
      repeat (3) @(posedge HCLK); #1;
      chk("rst_no_done_after", 32'(done_cnt), 32'(d0));
      run_cmd(1'b0, 10'h040, 5'd1, 0, 0, 0, 1, 3'b000, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
